alu_64: RTL and testbench

- 64-bit integer ALU for the datapath execute stage.
- Performs pass-B, add, subtract, AND, OR and XOR on two 64-bit operands and produces negative, zero, overflow and carry-out flags.
- Operation is combinational. Result and flags are captured in an output register, so outputs are valid one clock after the inputs settle.

---
 rtl/alu_64.sv | 107 ++++++++++
 tb/tb_alu_64.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_64.sv
`default_nettype none
// ============================================================================
// Module   : alu_64
// Purpose  : Integer ALU for the execute stage. The operation is computed
//            combinationally from A, B and cntrl. Result and flags are
//            captured in an output register, so they appear one clock later.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-high reset
//   A         in   WIDTH  operand A
//   B         in   WIDTH  operand B
//   cntrl     in   3      operation select
//   result    out  WIDTH  registered result
//   negative  out  1      registered result[WIDTH-1]
//   zero      out  1      registered (result == 0)
//   overflow  out  1      registered signed overflow (add/sub only)
//   carry_out out  1      registered adder carry out of the MSB (add/sub only)
// ============================================================================
module alu_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam logic [2:0] c_OP_PASSB = 3'b000;
  localparam logic [2:0] c_OP_ADD   = 3'b010;
  localparam logic [2:0] c_OP_SUB   = 3'b011;
  localparam logic [2:0] c_OP_AND   = 3'b100;
  localparam logic [2:0] c_OP_OR    = 3'b101;
  localparam logic [2:0] c_OP_XOR   = 3'b110;

  logic             w_is_sub;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_carry;

  // Single shared adder: subtract is A + ~B + 1.
  assign w_is_sub   = (cntrl == c_OP_SUB);
  assign w_is_arith = (cntrl == c_OP_ADD) || w_is_sub;
  assign w_b_eff    = w_is_sub ? ~B : B;
  assign w_sum      = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

  // Same-sign addends producing a different-sign sum is exactly
  // carry-into-MSB XOR carry-out-of-MSB.
  assign w_add_ovf  = (A[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    w_result = '0;
    unique case (cntrl)
      c_OP_PASSB:       w_result = B;
      c_OP_ADD, c_OP_SUB: w_result = w_sum[WIDTH-1:0];
      c_OP_AND:         w_result = A & B;
      c_OP_OR:          w_result = A | B;
      c_OP_XOR:         w_result = A ^ B;
      default:          w_result = '0;
    endcase
  end

  assign w_overflow = w_is_arith && w_add_ovf;
  assign w_carry    = w_is_arith && w_sum[WIDTH];

  logic [WIDTH-1:0] r_result;
  logic             r_negative;
  logic             r_zero;
  logic             r_overflow;
  logic             r_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result   <= '0;
      r_negative <= 1'b0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_negative <= w_result[WIDTH-1];
      r_zero     <= (w_result == '0);
      r_overflow <= w_overflow;
      r_carry    <= w_carry;
    end
  end

  assign result    = r_result;
  assign negative  = r_negative;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_64
// Purpose  : Directed self-checking bench for alu_64 with hand-computed
//            expected result and flags for every vector.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_64;

  logic        clk;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  int          vectors;
  int          miscompares;
  logic [63:0] last_res;
  bit          have_last;

  alu_64 #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [63:0] er,
                           input logic en, input logic ez,
                           input logic eo, input logic ec);
    assert (result === er) else begin
      miscompares++;
      $error("FAIL %s result observed=%h expected=%h", tag, result, er);
    end
    assert (negative === en) else begin
      miscompares++;
      $error("FAIL %s negative observed=%b expected=%b", tag, negative, en);
    end
    assert (zero === ez) else begin
      miscompares++;
      $error("FAIL %s zero observed=%b expected=%b", tag, zero, ez);
    end
    assert (overflow === eo) else begin
      miscompares++;
      $error("FAIL %s overflow observed=%b expected=%b", tag, overflow, eo);
    end
    assert (carry_out === ec) else begin
      miscompares++;
      $error("FAIL %s carry_out observed=%b expected=%b", tag, carry_out, ec);
    end
    last_res  = er;
    have_last = 1'b1;
  endtask

  // Drive on the falling edge, confirm the output still holds the previous
  // value before the rising edge, then check one rising edge later.
  task automatic step(input string tag, input logic [63:0] a,
                      input logic [63:0] b, input logic [2:0] op,
                      input logic [63:0] er, input logic en, input logic ez,
                      input logic eo, input logic ec);
    @(negedge clk);
    A = a; B = b; cntrl = op;
    vectors++;
    #1;
    if (have_last) begin
      assert (result === last_res) else begin
        miscompares++;
        $error("FAIL %s early_change observed=%h expected=%h", tag, result, last_res);
      end
    end
    @(posedge clk);
    #1;
    check_out(tag, er, en, ez, eo, ec);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    have_last   = 1'b0;
    last_res    = '0;
    reset       = 1'b0;
    A           = 64'd5;
    B           = 64'd7;
    cntrl       = 3'b010;

    // Load a non-zero value, then reset asynchronously between edges.
    step("pre_add", 64'd5, 64'd7, 3'b010, 64'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_held", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset", 64'd12, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pass-B
    step("passb_neg", 64'h0000_0000_0000_1234, 64'hDEAD_BEEF_0000_0000, 3'b000,
         64'hDEAD_BEEF_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("passb_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b000,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Add corners
    step("add_ff_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b010,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("add_3f_1", 64'h3FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010,
         64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("add_7f_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010,
         64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    step("add_7f_ff", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010,
         64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add_80_ff", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);

    // Subtract corners
    step("sub_3f_ff", 64'h3FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011,
         64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sub_7f_ff", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011,
         64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sub_80_1", 64'h8000_0000_0000_0000, 64'h1, 3'b011,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    step("sub_equal", 64'hDEAD_BEEF_DECA_FBAD, 64'hDEAD_BEEF_DECA_FBAD, 3'b011,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("sub_borrow", 64'd5, 64'd7, 3'b011,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);

    // Logic ops; the add just before must not leak carry into them
    step("add_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 3'b010,
         64'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("and", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b100,
         64'hF000_F000_F000_F000, 1'b1, 1'b0, 1'b0, 1'b0);
    step("or", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b101,
         64'hFFF0_FFF0_FFF0_FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("xor", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b110,
         64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("and_zero", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3'b100,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("xor_self", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b110,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Unused opcodes
    step("add_before_unused", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b010,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("op111", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b111,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("op001", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b001,
         64'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back opcode changes, one per cycle
    step("b2b_or", 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F, 3'b101,
         64'h0000_0000_0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step("b2b_add", 64'd100, 64'd23, 3'b010,
         64'd123, 1'b0, 1'b0, 1'b0, 1'b0);
    step("b2b_passb", 64'd100, 64'h8000_0000_0000_0001, 3'b000,
         64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b_sub", 64'd100, 64'd23, 3'b011,
         64'd77, 1'b0, 1'b0, 1'b0, 1'b1);
    step("b2b_xor", 64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_0000_0000, 3'b110,
         64'h0000_FFFF_FFFF_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
